// File: rtl/fib_scan_pkg.sv
// Shared types and constants for the Fibonacci range scanner.
// FIB_MASK is the golden recogniser hit set over all 4-bit values.
package fib_scan_pkg;

    localparam int NUM_W  = 4;
    localparam int MASK_W = 16;

    localparam logic [MASK_W-1:0] FIB_MASK = 16'h0737;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [MASK_W-1:0] onehot(input logic [NUM_W-1:0] v);
        return MASK_W'(1) << v;
    endfunction

endpackage

// File: rtl/fib_detect.sv
// Combinational recogniser for the 4-bit hit set {0,1,2,4,5,8,9,10}.
module fib_detect
    import fib_scan_pkg::*;
(
    input  logic [NUM_W-1:0] n,
    output logic             out
);

    assign out = (~n[0] & ~n[2])
               | (~n[1] & ~n[2])
               | (~n[1] & ~n[3]);

endmodule

// File: rtl/fib_scan_ctrl.sv
// Sweeps lo..hi (mod 16) through fib_detect, collecting a hit mask and count.
// Define FIB_PIPE_EN to register the recogniser output (adds a DRAIN state).
module fib_scan_ctrl
    import fib_scan_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_W-1:0]  lo,
    input  logic [NUM_W-1:0]  hi,
    output logic              busy,
    output logic              done,
    output logic [NUM_W-1:0]  number,
    output logic              hit,
    output logic [MASK_W-1:0] hit_mask,
    output logic [CNT_W-1:0]  hit_count
);

    state_t           state;
    state_t           state_n;
    logic [NUM_W-1:0] hi_q;
    logic             det;
    logic             load;
    logic             step;
    logic             last;
    logic             acc_en;
    logic             acc_hit;
    logic [NUM_W-1:0] acc_val;

    fib_detect u_detect (
        .n   (number),
        .out (det)
    );

    assign last = (number == hi_q);

`ifdef FIB_PIPE_EN
    logic             pipe_vld;
    logic             pipe_hit;
    logic [NUM_W-1:0] pipe_val;

    // Each SCAN cycle's result is accounted one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld <= 1'b0;
            pipe_hit <= 1'b0;
            pipe_val <= '0;
        end else begin
            pipe_vld <= (state == SCAN);
            pipe_hit <= det;
            pipe_val <= number;
        end
    end

    assign acc_en  = pipe_vld;
    assign acc_hit = pipe_hit;
    assign acc_val = pipe_val;
`else
    assign acc_en  = (state == SCAN);
    assign acc_hit = det;
    assign acc_val = number;
`endif

    assign hit = acc_en & acc_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (last) begin
`ifdef FIB_PIPE_EN
                    state_n = DRAIN;
`else
                    state_n = DONE;
`endif
                end else begin
                    step = 1'b1;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            number    <= '0;
            hi_q      <= '0;
            hit_mask  <= '0;
            hit_count <= '0;
        end else if (load) begin
            number    <= lo;
            hi_q      <= hi;
            hit_mask  <= '0;
            hit_count <= '0;
        end else begin
            if (step) begin
                number <= number + NUM_W'(1);
            end
            if (hit) begin
                hit_mask  <= hit_mask | onehot(acc_val);
                hit_count <= hit_count + CNT_W'(1);
            end
        end
    end

endmodule
